// File: rtl/instr_mem_pkg.sv
// Shared constants for the instruction prefetch memory.
// Holds the default parameter values and the instruction word returned
// for out-of-range fetches.
package instr_mem_pkg;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_ADDR_W     = 16;
    localparam int unsigned DEF_DEPTH      = 256;
    localparam int unsigned DEF_RD_LAT     = 1;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    // Instruction value carried by a faulting response.
    localparam int unsigned FAULT_INSTR    = 0;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous flush and asynchronous active-low reset.
// Ports:
//   clk, rst_n      clock and async active-low reset
//   flush           empties the FIFO at the next rising edge (dominates push/pop)
//   push, push_data write one entry (caller guarantees it is not full)
//   pop             remove the head entry (ignored when empty)
//   valid           FIFO holds at least one entry
//   pop_data        head entry; reads 0 while empty
module sync_fifo
    import instr_mem_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] pop_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_en;

    assign valid  = (count_q != '0);
    assign pop_en = pop && valid;

    // Pointers wrap naturally because DEPTH is a power of two; the count,
    // not pointer equality, tells full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            store[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = valid ? store[rd_ptr_q] : '0;

endmodule

// File: rtl/instruction_prefetch_mem.sv
// Instruction memory with a credit-based prefetch response buffer.
// Ports:
//   clk, rst_n                       clock and async active-low reset
//   req_valid, req_ready, req_addr   fetch request handshake and word address
//   rsp_valid, rsp_ready             response handshake
//   rsp_instr, rsp_addr, rsp_fault   response word, echoed address, out-of-range flag
//   flush                            drop every buffered and in-flight response
//   load_en, load_addr, load_data    program-load write port
//   occupancy                        buffered plus in-flight entries
// A request reserves a buffer credit when accepted, so the response buffer can
// never overflow regardless of how long rsp_ready stays low.
module instruction_prefetch_mem
    import instr_mem_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned RD_LAT     = DEF_RD_LAT,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_W-1:0]           req_addr,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_instr,
    output logic [ADDR_W-1:0]           rsp_addr,
    output logic                        rsp_fault,
    input  logic                        flush,
    input  logic                        load_en,
    input  logic [ADDR_W-1:0]           load_addr,
    input  logic [DATA_W-1:0]           load_data,
    output logic [$clog2(FIFO_DEPTH):0] occupancy
);

    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENT_W  = 1 + ADDR_W + DATA_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              req_ok;
    logic              load_ok;
    logic              accept;
    logic              pop;
    logic [DATA_W-1:0] rd_instr;
    logic [ENT_W-1:0]  req_entry;
    logic              push;
    logic [ENT_W-1:0]  push_entry;
    logic              fifo_valid;
    logic [ENT_W-1:0]  head;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;

    // Widen by one bit so DEPTH == 2**ADDR_W compares correctly.
    assign req_ok  = ({1'b0, req_addr} < DEPTH_L);
    assign load_ok = ({1'b0, load_addr} < DEPTH_L);

    // Not reset: program contents survive rst_n.
    always_ff @(posedge clk) begin
        if (load_en && load_ok) begin
            mem[load_addr[MEM_AW-1:0]] <= load_data;
        end
    end

    // Sampled on the accepting edge, so a same-edge load returns old data.
    assign rd_instr  = req_ok ? mem[req_addr[MEM_AW-1:0]] : DATA_W'(FAULT_INSTR);
    assign req_entry = {!req_ok, req_addr, rd_instr};

    assign req_ready = (occ_q < OCC_W'(FIFO_DEPTH)) && !flush;
    assign accept    = req_valid && req_ready;
    assign pop       = fifo_valid && rsp_ready && !flush;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(accept) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

    // RD_LAT=1 writes the buffer on the accepting edge; RD_LAT=2 adds one
    // pipeline stage whose contents are still counted in occupancy.
    if (RD_LAT == 1) begin : g_lat1
        assign push       = accept;
        assign push_entry = req_entry;
    end else begin : g_lat2
        logic             stg_valid_q;
        logic [ENT_W-1:0] stg_entry_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stg_valid_q <= 1'b0;
                stg_entry_q <= '0;
            end else begin
                // accept is already low while flushing.
                stg_valid_q <= accept;
                if (accept) begin
                    stg_entry_q <= req_entry;
                end
            end
        end

        assign push       = stg_valid_q && !flush;
        assign push_entry = stg_entry_q;
    end

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .valid     (fifo_valid),
        .pop_data  (head)
    );

    assign rsp_valid = fifo_valid;
    assign {rsp_fault, rsp_addr, rsp_instr} = head;

endmodule

// File: tb/tb_instruction_prefetch_mem.sv
// Self-checking bench for instruction_prefetch_mem (default parameters).
// A queue of expected responses plus a memory image predicts every output.
module tb_instruction_prefetch_mem;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;
    localparam int LAT   = 1;
    localparam int FD    = 4;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_instr;
    logic [AW-1:0] rsp_addr;
    logic          rsp_fault;
    logic          flush;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic [2:0]    occupancy;

    instruction_prefetch_mem dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault),
        .flush     (flush),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] instr;
        logic          fault;
        int            avail;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            cyc    = 0;
    int            n_cmp  = 0;
    int            n_bad  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic rr, input logic fl);
        req_valid = v;
        req_addr  = a;
        rsp_ready = rr;
        flush     = fl;
        load_en   = 1'b0;
    endtask

    // One clock cycle: check outputs mid-cycle, then apply the edge to the model.
    task automatic cycle();
        bit   exp_valid;
        bit   do_acc;
        bit   do_pop;
        rsp_t e;
        @(negedge clk);
        exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
        chk("req_ready", {31'b0, req_ready}, {31'b0, (exp_q.size() < FD) && !flush});
        chk("occupancy", {29'b0, occupancy}, exp_q.size());
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            chk("rsp_instr", {16'b0, rsp_instr}, {16'b0, exp_q[0].instr});
            chk("rsp_addr", {16'b0, rsp_addr}, {16'b0, exp_q[0].addr});
            chk("rsp_fault", {31'b0, rsp_fault}, {31'b0, exp_q[0].fault});
        end
        do_acc = req_valid && (exp_q.size() < FD) && !flush;
        do_pop = exp_valid && rsp_ready && !flush;
        @(posedge clk);
        cyc++;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_acc) begin
                e.addr  = req_addr;
                e.fault = (req_addr >= DEPTH);
                e.instr = e.fault ? '0 : ref_mem[req_addr[7:0]];
                e.avail = cyc + LAT - 1;
                exp_q.push_back(e);
            end
        end
        if (load_en && load_addr < DEPTH) ref_mem[load_addr[7:0]] = load_data;
        #1;
    endtask

    logic [DW-1:0] prog [4];

    initial begin
        prog[0] = 16'h1234;
        prog[1] = 16'hABCD;
        prog[2] = 16'h5678;
        prog[3] = 16'h9ABC;
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        load_addr = '0;
        load_data = '0;

        // Reset state
        #2;
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("reset_occupancy", {29'b0, occupancy}, 0);
        chk("reset_req_ready", {31'b0, req_ready}, 1);
        chk("reset_rsp_instr", {16'b0, rsp_instr}, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Program load: words 0..3 fixed, rest random
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            load_en   = 1'b1;
            load_addr = AW'(a);
            load_data = (a < 4) ? prog[a] : DW'($urandom);
            cycle();
        end
        // Out-of-range load must be ignored (low bits alias address 0)
        drive(1'b0, '0, 1'b1, 1'b0);
        load_en   = 1'b1;
        load_addr = 16'h0100;
        load_data = 16'hDEAD;
        cycle();

        // Back-to-back fetch 0..3
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, AW'(i), 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();
        cycle();

        // Back-pressure: only FIFO_DEPTH accepts, head stable, then drain
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, AW'(4 + i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle();

        // Out-of-range fetches
        drive(1'b1, 16'h0100, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 16'hFFFF, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();
        cycle();

        // Flush with entries buffered; request during flush must not be taken
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, AW'(5 + i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 16'h0003, 1'b1, 1'b1);
        cycle();
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 16'h0001, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();

        // Read and load of address 2 on the same edge
        drive(1'b1, 16'h0002, 1'b1, 1'b0);
        load_en   = 1'b1;
        load_addr = 16'h0002;
        load_data = 16'h1111;
        cycle();
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 16'h0002, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();

        // Randomised traffic; loads avoid addresses 0..3
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0) ? AW'($urandom_range(256, 65535))
                                              : AW'($urandom_range(0, 255)),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 29) == 0));
            load_en   = ($urandom_range(0, 4) == 0);
            load_addr = AW'($urandom_range(4, 300));
            load_data = DW'($urandom);
            cycle();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle();

        // Reset between edges while entries are buffered
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'h0009, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("midrst_occupancy", {29'b0, occupancy}, 0);
        chk("midrst_req_ready", {31'b0, req_ready}, 1);
        chk("midrst_rsp_instr", {16'b0, rsp_instr}, 0);
        chk("midrst_rsp_addr", {16'b0, rsp_addr}, 0);
        chk("midrst_rsp_fault", {31'b0, rsp_fault}, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();
        cycle();
        drive(1'b1, 16'h0000, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
